operand_read_stage: RTL and testbench

//  Parametrised register-read pipeline stage between Decode and Execute.

---
 rtl/operand_read_pkg.sv | 23 ++
 rtl/read_bypass_mux.sv | 45 ++++
 rtl/operand_read_stage.sv | 202 ++++++++++++++++++++
 tb/tb_operand_read_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_read_pkg.sv
// Shared types and constants for the operand-read stage.
package operand_read_pkg;

  // Default architectural register count and the matching index width
  localparam int NUM_REGS_DEF = 16;
  localparam int RIDX_W       = $clog2(NUM_REGS_DEF);

  // Read-request index width; wide enough for any register file up to 256 entries
  localparam int IDX_W = 8;

  // Stack pointer (RSP) register index
  localparam int SP_REG = 4;

  // RETQ opcode byte as produced by Decode
  localparam logic [7:0] RET_OPCODE = 8'hC3;

  // One register read request: which register, and whether the read is wanted
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             valid;
  } rd_req_t;

endpackage

// File: rtl/read_bypass_mux.sv
// Register read with writeback bypass: the highest-index writeback port that
// targets the requested register supplies the value, otherwise the
// architectural register file does.
module read_bypass_mux
  import operand_read_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 16,
  parameter int NUM_WB   = 1,
  parameter int RIDX_W   = 4
) (
  input  rd_req_t                           i_req,
  input  logic [NUM_REGS-1:0][XLEN-1:0]     i_regfile,
  input  logic [NUM_WB-1:0]                 i_wb_valid,
  input  logic [NUM_WB-1:0][RIDX_W-1:0]     i_wb_reg,
  input  logic [NUM_WB-1:0][XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]                   o_value,
  output logic                              o_wb_hit
);

  logic [XLEN-1:0] w_value;
  logic            w_hit;

  // Start from the register file, then let matching writeback ports override in ascending order so the highest index wins
  always_comb begin
    w_value = '0;
    w_hit   = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (IDX_W'(r) == i_req.idx) begin
        w_value = i_regfile[r];
      end
    end
    for (int w = 0; w < NUM_WB; w++) begin
      if (i_wb_valid[w] && (IDX_W'(i_wb_reg[w]) == i_req.idx)) begin
        w_value = i_wb_data[w];
        w_hit   = 1'b1;
      end
    end
  end

  assign o_value  = w_value;
  // A hit only matters for reads that are actually requested
  assign o_wb_hit = w_hit && i_req.valid;

endmodule

// File: rtl/operand_read_stage.sv
// Register-read stage between Decode and Execute: bypassed operand reads,
// pending-write scoreboard with RAW/WAW stall, RETQ stack-pointer injection,
// and a single valid/ready output register.
module operand_read_stage
  import operand_read_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int NUM_REGS   = 16,
  parameter int NUM_SRC    = 2,
  parameter int NUM_WB     = 1,
  parameter int SIDEBAND_W = 512,
  parameter int SP_REG     = operand_read_pkg::SP_REG,
  localparam int RIDX_W    = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_SRC-1:0][RIDX_W-1:0]    in_src_reg,
  input  logic [NUM_SRC-1:0]                in_src_valid,
  input  logic [RIDX_W-1:0]                 in_dst_reg,
  input  logic                              in_dst_valid,
  input  logic                              in_is_ret,
  input  logic [SIDEBAND_W-1:0]             in_sideband,
  input  logic [NUM_REGS-1:0][XLEN-1:0]     regfile_in,
  input  logic [NUM_WB-1:0]                 wb_valid,
  input  logic [NUM_WB-1:0][RIDX_W-1:0]     wb_reg,
  input  logic [NUM_WB-1:0][XLEN-1:0]       wb_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_SRC-1:0][XLEN-1:0]      out_operand,
  output logic [NUM_SRC-1:0]                out_operand_valid,
  output logic [NUM_SRC-1:0][RIDX_W-1:0]    out_src_reg,
  output logic [RIDX_W-1:0]                 out_dst_reg,
  output logic                              out_dst_valid,
  output logic [XLEN-1:0]                   out_dst_value,
  output logic                              out_src0_mem,
  output logic [SIDEBAND_W-1:0]             out_sideband
);

  // Read lanes: sources first, then destination, then the stack pointer
  localparam int NREQ     = NUM_SRC + 2;
  localparam int DST_LANE = NUM_SRC;
  localparam int RSP_LANE = NUM_SRC + 1;

  rd_req_t         w_req [NREQ];
  logic [XLEN-1:0] w_val [NREQ];
  logic [NREQ-1:0] w_hit;

  // Effective operand lanes after RETQ substitution on lane 0
  logic [NUM_SRC-1:0][RIDX_W-1:0] w_eff_idx;
  logic [NUM_SRC-1:0]             w_eff_valid;
  logic [NUM_SRC-1:0][XLEN-1:0]   w_eff_val;
  logic [NUM_SRC-1:0]             w_eff_hit;

  logic [NUM_REGS-1:0] r_sb;
  logic [NUM_REGS-1:0] w_sb_next;
  logic                w_hazard;
  logic                w_fire;

  logic                           r_out_valid;
  logic [NUM_SRC-1:0][XLEN-1:0]   r_operand;
  logic [NUM_SRC-1:0]             r_operand_valid;
  logic [NUM_SRC-1:0][RIDX_W-1:0] r_src_reg;
  logic [RIDX_W-1:0]              r_dst_reg;
  logic                           r_dst_valid;
  logic [XLEN-1:0]                r_dst_value;
  logic                           r_src0_mem;
  logic [SIDEBAND_W-1:0]          r_sideband;

  genvar gi;

  // Build read requests for every lane
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src_req
      assign w_req[gi] = '{idx: IDX_W'(in_src_reg[gi]), valid: in_src_valid[gi]};
    end
  endgenerate
  assign w_req[DST_LANE] = '{idx: IDX_W'(in_dst_reg), valid: in_dst_valid};
  assign w_req[RSP_LANE] = '{idx: IDX_W'(SP_REG),     valid: in_is_ret};

  // One bypassed read per lane
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_read
      read_bypass_mux #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .NUM_WB   (NUM_WB),
        .RIDX_W   (RIDX_W)
      ) u_mux (
        .i_req      (w_req[gi]),
        .i_regfile  (regfile_in),
        .i_wb_valid (wb_valid),
        .i_wb_reg   (wb_reg),
        .i_wb_data  (wb_data),
        .o_value    (w_val[gi]),
        .o_wb_hit   (w_hit[gi])
      );
    end
  endgenerate

  // RETQ replaces source 0 with RSP; other lanes pass straight through
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_lane
      if (gi == 0) begin : g_ret
        assign w_eff_idx[gi]   = in_is_ret ? RIDX_W'(SP_REG) : in_src_reg[gi];
        assign w_eff_valid[gi] = in_is_ret ? 1'b1 : in_src_valid[gi];
        assign w_eff_val[gi]   = in_is_ret ? w_val[RSP_LANE] : w_val[gi];
        assign w_eff_hit[gi]   = in_is_ret ? w_hit[RSP_LANE] : w_hit[gi];
      end else begin : g_plain
        assign w_eff_idx[gi]   = in_src_reg[gi];
        assign w_eff_valid[gi] = in_src_valid[gi];
        assign w_eff_val[gi]   = w_val[gi];
        assign w_eff_hit[gi]   = w_hit[gi];
      end
    end
  endgenerate

  // Stall when any used register has a pending write not being resolved by writeback this cycle
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_eff_valid[i] && r_sb[w_eff_idx[i]] && !w_eff_hit[i]) begin
        w_hazard = 1'b1;
      end
    end
    if (in_dst_valid && r_sb[in_dst_reg] && !w_hit[DST_LANE]) begin
      w_hazard = 1'b1;
    end
  end

  assign in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_fire   = in_valid && in_ready;

  // Scoreboard update: writebacks clear, a firing writer sets (set wins), flush wipes everything
  always_comb begin
    w_sb_next = r_sb;
    for (int w = 0; w < NUM_WB; w++) begin
      if (wb_valid[w]) begin
        w_sb_next[wb_reg[w]] = 1'b0;
      end
    end
    if (w_fire && in_dst_valid) begin
      w_sb_next[in_dst_reg] = 1'b1;
    end
    if (flush) begin
      w_sb_next = '0;
    end
  end

  // Pending-write scoreboard register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_next;
    end
  end

  // Output register: capture on fire, drop valid on drain or flush, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid     <= 1'b0;
      r_operand       <= '0;
      r_operand_valid <= '0;
      r_src_reg       <= '0;
      r_dst_reg       <= '0;
      r_dst_valid     <= 1'b0;
      r_dst_value     <= '0;
      r_src0_mem      <= 1'b0;
      r_sideband      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_operand[i] <= w_eff_valid[i] ? w_eff_val[i] : '0;
      end
      r_operand_valid <= w_eff_valid;
      r_src_reg       <= w_eff_idx;
      r_dst_reg       <= in_dst_reg;
      r_dst_valid     <= in_dst_valid;
      r_dst_value     <= in_dst_valid ? w_val[DST_LANE] : '0;
      r_src0_mem      <= in_is_ret;
      r_sideband      <= in_sideband;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid         = r_out_valid;
  assign out_operand       = r_operand;
  assign out_operand_valid = r_operand_valid;
  assign out_src_reg       = r_src_reg;
  assign out_dst_reg       = r_dst_reg;
  assign out_dst_valid     = r_dst_valid;
  assign out_dst_value     = r_dst_value;
  assign out_src0_mem      = r_src0_mem;
  assign out_sideband      = r_sideband;

endmodule

// File: tb/tb_operand_read_stage.sv
// Directed bench for operand_read_stage with an expected-result queue.
module tb_operand_read_stage;

  logic                 clk;
  logic                 reset_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0][3:0]      in_src_reg;
  logic [1:0]           in_src_valid;
  logic [3:0]           in_dst_reg;
  logic                 in_dst_valid;
  logic                 in_is_ret;
  logic [511:0]         in_sideband;
  logic [15:0][63:0]    regfile_in;
  logic [0:0]           wb_valid;
  logic [0:0][3:0]      wb_reg;
  logic [0:0][63:0]     wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0][63:0]     out_operand;
  logic [1:0]           out_operand_valid;
  logic [1:0][3:0]      out_src_reg;
  logic [3:0]           out_dst_reg;
  logic                 out_dst_valid;
  logic [63:0]          out_dst_value;
  logic                 out_src0_mem;
  logic [511:0]         out_sideband;

  operand_read_stage dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_src_reg        (in_src_reg),
    .in_src_valid      (in_src_valid),
    .in_dst_reg        (in_dst_reg),
    .in_dst_valid      (in_dst_valid),
    .in_is_ret         (in_is_ret),
    .in_sideband       (in_sideband),
    .regfile_in        (regfile_in),
    .wb_valid          (wb_valid),
    .wb_reg            (wb_reg),
    .wb_data           (wb_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_operand       (out_operand),
    .out_operand_valid (out_operand_valid),
    .out_src_reg       (out_src_reg),
    .out_dst_reg       (out_dst_reg),
    .out_dst_valid     (out_dst_valid),
    .out_dst_value     (out_dst_value),
    .out_src0_mem      (out_src0_mem),
    .out_sideband      (out_sideband)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0][63:0] opnd;
    logic [1:0]       opv;
    logic [1:0][3:0]  src;
    logic [3:0]       dst;
    logic             dstv;
    logic [63:0]      dval;
    logic             mem;
    logic [511:0]     sb;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] tb_rf [16];
  logic [15:0] tb_sb;
  logic        tb_ov;
  int          total;
  int          bad;

  // Register file contents seen by the DUT
  always_comb begin
    for (int r = 0; r < 16; r++) regfile_in[r] = tb_rf[r];
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of register r as the stage should read it this cycle
  function automatic logic [63:0] read_val(input logic [3:0] r);
    if (wb_valid[0] && wb_reg[0] == r) return wb_data[0];
    return tb_rf[r];
  endfunction

  function automatic logic [3:0] eff_idx(input int i);
    if (i == 0 && in_is_ret) return 4'd4;
    return in_src_reg[i];
  endfunction

  function automatic logic eff_valid(input int i);
    if (i == 0 && in_is_ret) return 1'b1;
    return in_src_valid[i];
  endfunction

  function automatic logic wb_writes(input logic [3:0] r);
    return wb_valid[0] && (wb_reg[0] == r);
  endfunction

  function automatic logic model_ready();
    logic haz;
    haz = 1'b0;
    for (int i = 0; i < 2; i++)
      if (eff_valid(i) && tb_sb[eff_idx(i)] && !wb_writes(eff_idx(i))) haz = 1'b1;
    if (in_dst_valid && tb_sb[in_dst_reg] && !wb_writes(in_dst_reg)) haz = 1'b1;
    return !flush && !haz && (!tb_ov || out_ready);
  endfunction

  function automatic exp_t build_exp();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.opv[i]  = eff_valid(i);
      e.src[i]  = eff_idx(i);
      e.opnd[i] = eff_valid(i) ? read_val(eff_idx(i)) : 64'h0;
    end
    e.dst  = in_dst_reg;
    e.dstv = in_dst_valid;
    e.dval = read_val(in_dst_reg);
    e.mem  = in_is_ret;
    e.sb   = in_sideband;
    return e;
  endfunction

  // One clock: check outputs and handshake at the falling edge, then advance the model past the rising edge
  task automatic cycle();
    logic       rdy;
    logic       fire;
    logic [15:0] sb_n;
    logic       ov_n;
    exp_t       e;
    @(negedge clk);
    rdy = model_ready();
    if (in_valid) chk("in_ready", 512'(in_ready), 512'(rdy));
    if (tb_ov) begin
      e = exp_q[0];
      chk("out_valid", 512'(out_valid), 512'(1'b1));
      chk("operand0", 512'(out_operand[0]), 512'(e.opnd[0]));
      chk("operand1", 512'(out_operand[1]), 512'(e.opnd[1]));
      chk("operand_valid", 512'(out_operand_valid), 512'(e.opv));
      for (int i = 0; i < 2; i++)
        if (e.opv[i]) chk("src_reg", 512'(out_src_reg[i]), 512'(e.src[i]));
      chk("dst_valid", 512'(out_dst_valid), 512'(e.dstv));
      if (e.dstv) begin
        chk("dst_reg", 512'(out_dst_reg), 512'(e.dst));
        chk("dst_value", 512'(out_dst_value), 512'(e.dval));
      end
      chk("src0_mem", 512'(out_src0_mem), 512'(e.mem));
      chk("sideband", out_sideband, e.sb);
    end else begin
      chk("out_valid_idle", 512'(out_valid), 512'(1'b0));
    end
    fire = in_valid && rdy;
    if (tb_ov && (out_ready || flush)) void'(exp_q.pop_front());
    if (fire) exp_q.push_back(build_exp());
    sb_n = tb_sb;
    if (wb_valid[0]) sb_n[wb_reg[0]] = 1'b0;
    if (fire && in_dst_valid) sb_n[in_dst_reg] = 1'b1;
    if (flush) sb_n = '0;
    ov_n = flush ? 1'b0 : (fire ? 1'b1 : (tb_ov && !out_ready));
    @(posedge clk);
    #1;
    if (wb_valid[0]) tb_rf[wb_reg[0]] = wb_data[0];
    tb_sb = sb_n;
    tb_ov = ov_n;
    wb_valid = '0;
    flush = 1'b0;
  endtask

  task automatic new_sideband();
    for (int k = 0; k < 16; k++) in_sideband[k*32 +: 32] = $urandom;
  endtask

  task automatic set_instr(input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] sv,
                           input logic [3:0] d, input logic dv, input logic ret);
    in_valid = 1'b1;
    in_src_reg[0] = s0;
    in_src_reg[1] = s1;
    in_src_valid = sv;
    in_dst_reg = d;
    in_dst_valid = dv;
    in_is_ret = ret;
    new_sideband();
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_src_valid = '0;
    in_dst_valid = 1'b0;
    in_is_ret = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    tb_sb = '0;
    tb_ov = 1'b0;
    for (int r = 0; r < 16; r++) tb_rf[r] = 64'h1000 + 64'(r);
    tb_rf[1] = 64'h11;
    tb_rf[2] = 64'h22;
    tb_rf[4] = 64'h7FF0;
    tb_rf[5] = 64'h0;
    reset_n = 1'b0;
    flush = 1'b0;
    in_src_reg = '0;
    in_dst_reg = '0;
    in_sideband = '0;
    wb_valid = '0;
    wb_reg = '0;
    wb_data = '0;
    out_ready = 1'b1;
    idle_in();

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 512'(out_valid), 512'(1'b0));
    chk("rst_operand", 512'(out_operand), 512'(0));
    chk("rst_operand_valid", 512'(out_operand_valid), 512'(0));
    chk("rst_dst_valid", 512'(out_dst_valid), 512'(1'b0));
    chk("rst_src0_mem", 512'(out_src0_mem), 512'(1'b0));
    chk("rst_sideband", out_sideband, 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(1'b1));
    @(posedge clk);
    #1;

    // Plain two-source read
    set_instr(4'd1, 4'd2, 2'b11, 4'd0, 1'b0, 1'b0);
    cycle();
    idle_in();
    cycle();

    // RAW stall on R3 until its writeback arrives and is forwarded
    set_instr(4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0);
    cycle();
    set_instr(4'd3, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
    cycle();
    cycle();
    wb_valid = 1'b1; wb_reg[0] = 4'd3; wb_data[0] = 64'hAB;
    cycle();
    idle_in();
    cycle();

    // RETQ: RSP injected as operand 0 overriding the decoded source 0
    set_instr(4'd7, 4'd0, 2'b01, 4'd0, 1'b0, 1'b1);
    cycle();
    idle_in();
    cycle();

    // Back-pressure: output held for three cycles, next instruction waits
    out_ready = 1'b0;
    set_instr(4'd1, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);
    cycle();
    set_instr(4'd2, 4'd1, 2'b11, 4'd0, 1'b0, 1'b0);
    repeat (3) cycle();
    out_ready = 1'b1;
    cycle();
    idle_in();
    cycle();
    wb_valid = 1'b1; wb_reg[0] = 4'd6; wb_data[0] = 64'h66;
    cycle();

    // Same-cycle writeback beats the stale register file
    set_instr(4'd5, 4'd2, 2'b11, 4'd5, 1'b1, 1'b0);
    wb_valid = 1'b1; wb_reg[0] = 4'd5; wb_data[0] = 64'h1;
    cycle();
    idle_in();
    cycle();
    wb_valid = 1'b1; wb_reg[0] = 4'd5; wb_data[0] = 64'h55;
    cycle();

    // Flush with R3 pending and a valid output
    out_ready = 1'b0;
    set_instr(4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0);
    cycle();
    idle_in();
    flush = 1'b1;
    wb_valid = 1'b1; wb_reg[0] = 4'd3; wb_data[0] = 64'hCD;
    #1 chk("flush_in_ready", 512'(in_ready), 512'(1'b0));
    cycle();
    out_ready = 1'b1;
    set_instr(4'd3, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
    cycle();
    idle_in();
    cycle();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    set_instr(4'd0, 4'd0, 2'b00, 4'd9, 1'b1, 1'b0);
    cycle();
    idle_in();
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 512'(out_valid), 512'(1'b0));
    chk("midrst_sideband", out_sideband, 512'(0));
    tb_sb = '0;
    tb_ov = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    set_instr(4'd9, 4'd1, 2'b11, 4'd0, 1'b0, 1'b0);
    cycle();
    idle_in();

    // Drain anything still expected
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) cycle();
    chk("queue_empty", 512'(exp_q.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
